shape_stats_accumulator: RTL and testbench
==========================================

Name: shape_stats_accumulator

Overview:
- Consumes decoded shape records (type, width, height) from the shape-record source stage.
- Computes each record's area and keeps, per shape type, a running count and an area sum.
- On request, streams three per-type summary beats (rectangle, square, triangle) to the reporting stage.
- Integer hardware counterpart of the shape factory/reporter flow; sits between the record parser and the report sink.

Parameters:
DW, 16, width of in_w / in_h (unsigned integers)
CNT_W, 16, width of each per-type record counter
SUM_W, 40, width of each per-type area accumulator (must be >= 2*DW)
CLR_ON_REPORT, 1, 1 = clear all counters and sums after the last report beat; 0 = keep them

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input record valid
in_ready  out  1  block can accept a record
in_type  in  2  0=rectangle, 1=square, 2=triangle, 3=illegal
in_w  in  DW  width (side length for square)
in_h  in  DW  height (ignored for square)
report_req  in  1  level request to emit summary
out_valid  out  1  summary beat valid
out_ready  in  1  sink accepts beat
out_type  out  2  type of current summary beat
out_count  out  CNT_W  records of that type since last clear
out_area  out  SUM_W  area sum of that type
out_last  out  1  high on final (triangle) beat
err_illegal  out  1  one-cycle pulse on an illegal record
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert handled externally): state=IDLE; all counters/sums=0; out_valid=0, out_type=0, out_count=0, out_area=0, out_last=0, err_illegal=0, busy=0. Reset mid-CALC or mid-REPORT aborts immediately; the pending record and partial report are discarded.
- FSM states: IDLE, CALC, REPORT, CLEAR.
- IDLE: in_ready=1.
  - report_req=1 -> REPORT, with beat index=0. report_req has priority; when report_req and in_valid are both high, no record is accepted (in_ready is forced to 0 that cycle).
  - Else in_valid=1 -> capture type/w/h, go to CALC.
- CALC (exactly one cycle, in_ready=0): area computed from the captured operands.
  - rectangle: w*h.
  - square: w*w.
  - triangle: (w*h)>>1, truncated.
  - Product is 2*DW bits, zero-extended to SUM_W.
  - Type's sum += area and count += 1. Both saturate at all-ones: no wrap; a saturated value holds.
  - Illegal type: no update; err_illegal=1 for this cycle only.
  - Next state is IDLE. Throughput: one record per 2 cycles. Record accepted at edge N is visible in the sums after edge N+1.
- REPORT (in_ready=0): beats for type 0, 1, 2 in order.
  - out_valid=1; out_type=index; out_count/out_area = that type's values; out_last=(index==2).
  - Outputs are registered and held stable while out_valid && !out_ready.
  - Beat advances on out_valid && out_ready; no bubble between beats when out_ready stays high.
  - After the index-2 handshake: CLEAR if CLR_ON_REPORT=1, else IDLE. out_valid drops the cycle after the last handshake.
  - report_req is ignored while in REPORT.
- CLEAR (one cycle): all counters/sums = 0; next state IDLE.
- A zero dimension is legal: count increments, sum unchanged.
- busy=1 in CALC, REPORT and CLEAR.

Test Plan:
- Records rect(3,4), square(5,x), triangle(3,5), then report_req with out_ready=1 -> beats (0,1,12), (1,1,25), (2,1,7); out_last only on the third beat; then sums are cleared.
- Back-to-back rect(2,2) x4 with in_valid held -> in_ready toggles 1,0,1,0; rect count=4, area=16.
- Illegal type 3, w=9, h=9 -> err_illegal pulses exactly one cycle in CALC; all counts and sums stay 0; the following report shows zeros.
- Report with out_ready low for 5 cycles on beat 1 -> beat-1 values held stable; no beat skipped; total of 3 handshakes.
- report_req and in_valid asserted together in IDLE -> record not accepted (in_ready=0); report runs first; record is accepted after return to IDLE.
- rst_n pulled low mid-REPORT (after beat 0) -> out_valid=0 asynchronously; a new report after reset returns all zeros. Saturation check with CNT_W=2: five rect(1,1) -> count=3.

Source files
------------

// File: rtl/shape_stats_accumulator.sv
// ----------------------------------------------------------------------------
// shape_stats_accumulator
//   Accepts decoded shape records (type, width, height). Each record's area is
//   computed and added to a per-type running count and area sum. On a report
//   request, three summary beats go out in order: rectangle, square, triangle.
//   When CLR_ON_REPORT is set, all counters and sums are cleared after the
//   final beat.
//
// Ports
//   clk, rst_n          clock (rising edge); async active-low reset
//   in_valid/in_ready   record handshake; in_type 0=rect 1=square 2=tri 3=illegal
//   in_w, in_h          unsigned dimensions (in_h is ignored for a square)
//   report_req          level request for a summary (wins over in_valid in IDLE)
//   out_valid/out_ready summary beat handshake
//   out_type/out_count/out_area/out_last  contents of the current summary beat
//   err_illegal         one-cycle pulse while an illegal record is processed
//   busy                high whenever the block is not idle
// ----------------------------------------------------------------------------

// Per-type accumulator lane: saturating record counter and saturating area sum.
module shape_type_acc #(
    parameter int CNT_W = 16,
    parameter int SUM_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add_en,
    input  logic [SUM_W-1:0] area,
    output logic [CNT_W-1:0] cnt,
    output logic [SUM_W-1:0] sum
);
    // The extra top bit is the carry-out; once it is set the sum pins at all-ones.
    logic [SUM_W:0] sum_ext;
    assign sum_ext = {1'b0, sum} + {1'b0, area};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sum <= '0;
        end else if (clr) begin
            cnt <= '0;
            sum <= '0;
        end else if (add_en) begin
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
            sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        end
    end
endmodule

module shape_stats_accumulator #(
    parameter int DW            = 16,
    parameter int CNT_W         = 16,
    parameter int SUM_W         = 40,
    parameter int CLR_ON_REPORT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_type,
    input  logic [DW-1:0]    in_w,
    input  logic [DW-1:0]    in_h,
    input  logic             report_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_type,
    output logic [CNT_W-1:0] out_count,
    output logic [SUM_W-1:0] out_area,
    output logic             out_last,
    output logic             err_illegal,
    output logic             busy
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_REPORT, S_CLEAR} state_t;

    state_t state_q, state_d;

    logic [1:0]               cap_type;
    logic [DW-1:0]            cap_w, cap_h, op_b;
    logic [2*DW-1:0]          prod;
    logic [SUM_W-1:0]         area;
    logic [2:0][CNT_W-1:0]    cnt_all;
    logic [2:0][SUM_W-1:0]    sum_all;
    logic                     accept, hs, last_hs;
    logic [1:0]               nxt_idx;

    // A pending report blocks new records, so a record can never slip in
    // between the request and the first beat.
    assign in_ready = (state_q == S_IDLE) && !report_req;
    assign accept   = in_valid && in_ready;
    assign hs       = out_valid && out_ready;
    assign last_hs  = hs && (out_type == 2'd2);
    assign nxt_idx  = out_type + 2'd1;

    assign busy        = (state_q != S_IDLE);
    assign err_illegal = (state_q == S_CALC) && (cap_type == 2'd3);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (report_req)    state_d = S_REPORT;
                else if (in_valid) state_d = S_CALC;
            end
            S_CALC:   state_d = S_IDLE;
            S_REPORT: if (last_hs) state_d = (CLR_ON_REPORT != 0) ? S_CLEAR : S_IDLE;
            S_CLEAR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- record capture and area ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_type <= '0;
            cap_w    <= '0;
            cap_h    <= '0;
        end else if (accept) begin
            cap_type <= in_type;
            cap_w    <= in_w;
            cap_h    <= in_h;
        end
    end

    // Square reuses the width as both operands; triangle halves the full product.
    assign op_b = (cap_type == 2'd1) ? cap_w : cap_h;
    always_comb begin
        prod = {{DW{1'b0}}, cap_w} * {{DW{1'b0}}, op_b};
        if (cap_type == 2'd2) prod = prod >> 1;
    end
    assign area = SUM_W'(prod);

    // ---------------- per-type lanes ----------------
    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam logic [1:0] TYPE = 2'(g);
        shape_type_acc #(.CNT_W(CNT_W), .SUM_W(SUM_W)) u_acc (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (state_q == S_CLEAR),
            .add_en ((state_q == S_CALC) && (cap_type == TYPE)),
            .area   (area),
            .cnt    (cnt_all[g]),
            .sum    (sum_all[g])
        );
    end

    // ---------------- report beats ----------------
    // out_type doubles as the beat index. Beat 0 is loaded on the way into
    // REPORT so the first beat is valid on the first REPORT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_type  <= '0;
            out_count <= '0;
            out_area  <= '0;
            out_last  <= 1'b0;
        end else if (state_q == S_IDLE && report_req) begin
            out_valid <= 1'b1;
            out_type  <= 2'd0;
            out_count <= cnt_all[0];
            out_area  <= sum_all[0];
            out_last  <= 1'b0;
        end else if (state_q == S_REPORT && hs) begin
            if (out_type == 2'd2) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                out_type  <= nxt_idx;
                out_count <= cnt_all[nxt_idx];
                out_area  <= sum_all[nxt_idx];
                out_last  <= (nxt_idx == 2'd2);
            end
        end
    end
endmodule

// File: tb/tb_shape_stats_accumulator.sv
module tb_shape_stats_accumulator;
    localparam int DW = 16, CNT_W = 16, SUM_W = 40;
    localparam int SDW = 4, SCNT_W = 2, SSUM_W = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, report_req = 1'b0;
    logic [1:0] in_type = '0;
    logic [DW-1:0] in_w = '0, in_h = '0;
    logic rnd_ready = 1'b0, rnd_bit = 1'b0, dir_ready = 1'b1;
    logic out_ready;
    assign out_ready = rnd_ready ? rnd_bit : dir_ready;

    // main instance (default parameters, clear on report)
    logic in_ready, out_valid, out_last, err_illegal, busy;
    logic [1:0] out_type;
    logic [CNT_W-1:0] out_count;
    logic [SUM_W-1:0] out_area;

    // small instance: narrow widths for saturation, keeps totals across reports
    logic s_in_valid, s_in_ready, s_out_valid, s_out_last, s_err_illegal, s_busy;
    logic [1:0] s_out_type;
    logic [SCNT_W-1:0] s_out_count;
    logic [SSUM_W-1:0] s_out_area;
    assign s_in_valid = in_valid && in_ready;

    shape_stats_accumulator #(.DW(DW), .CNT_W(CNT_W), .SUM_W(SUM_W), .CLR_ON_REPORT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_w(in_w), .in_h(in_h), .report_req(report_req), .out_valid(out_valid),
        .out_ready(out_ready), .out_type(out_type), .out_count(out_count), .out_area(out_area),
        .out_last(out_last), .err_illegal(err_illegal), .busy(busy));

    shape_stats_accumulator #(.DW(SDW), .CNT_W(SCNT_W), .SUM_W(SSUM_W), .CLR_ON_REPORT(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_type(in_type),
        .in_w(in_w[SDW-1:0]), .in_h(in_h[SDW-1:0]), .report_req(report_req), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_type(s_out_type), .out_count(s_out_count), .out_area(s_out_area),
        .out_last(s_out_last), .err_illegal(s_err_illegal), .busy(s_busy));

    always #5 clk = ~clk;

    typedef struct { int t; longint c; longint a; bit l; } beat_t;
    beat_t exp_q[$], s_exp_q[$];
    int checks = 0, failures = 0, hs_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        checks++;
        failures++;
        $display("FAIL timeout %s", nm);
    endtask

    // ---------------- reference model ----------------
    longint m_cnt[3], m_sum[3], s_cnt[3], s_sum[3];

    function automatic longint area_of(input int t, input longint w, input longint h);
        case (t)
            0: return w * h;
            1: return w * w;
            2: return (w * h) / 2;
            default: return 0;
        endcase
    endfunction

    function automatic longint sat(input longint v, input longint d, input int bits);
        longint mx = (longint'(1) << bits) - 1;
        return (v + d > mx) ? mx : v + d;
    endfunction

    task automatic model_rec(input int t, input int w, input int h);
        if (t == 3) return;
        m_cnt[t] = sat(m_cnt[t], 1, CNT_W);
        m_sum[t] = sat(m_sum[t], area_of(t, w, h), SUM_W);
        s_cnt[t] = sat(s_cnt[t], 1, SCNT_W);
        s_sum[t] = sat(s_sum[t], area_of(t, w % 16, h % 16), SSUM_W);
    endtask

    task automatic model_zero(input bit both);
        for (int t = 0; t < 3; t++) begin
            m_cnt[t] = 0; m_sum[t] = 0;
            if (both) begin s_cnt[t] = 0; s_sum[t] = 0; end
        end
    endtask

    // Expected beats for a report; the main instance then starts from zero.
    task automatic push_report();
        for (int t = 0; t < 3; t++) begin
            exp_q.push_back('{t, m_cnt[t], m_sum[t], t == 2});
            s_exp_q.push_back('{t, s_cnt[t], s_sum[t], t == 2});
        end
        model_zero(1'b0);
    endtask

    // ---------------- monitors ----------------
    initial begin
        logic [63:0] h_t, h_c, h_a, h_l;
        bit stall = 0;
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (stall) begin
                    check("hold_type", 64'(out_type), h_t);
                    check("hold_count", 64'(out_count), h_c);
                    check("hold_area", 64'(out_area), h_a);
                    check("hold_last", 64'(out_last), h_l);
                end
                if (out_ready) begin
                    hs_cnt++;
                    stall = 0;
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_beat type=%0d count=%0d", out_type, out_count);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_type", 64'(out_type), 64'(b.t));
                        check("beat_count", 64'(out_count), 64'(b.c));
                        check("beat_area", 64'(out_area), 64'(b.a));
                        check("beat_last", 64'(out_last), 64'(b.l));
                    end
                end else begin
                    stall = 1;
                    h_t = 64'(out_type); h_c = 64'(out_count); h_a = 64'(out_area); h_l = 64'(out_last);
                end
            end else stall = 0;
        end
    end

    initial begin
        logic [63:0] h_t, h_c, h_a;
        bit stall = 0;
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n && s_out_valid) begin
                if (stall) begin
                    check("s_hold_type", 64'(s_out_type), h_t);
                    check("s_hold_count", 64'(s_out_count), h_c);
                    check("s_hold_area", 64'(s_out_area), h_a);
                end
                if (out_ready) begin
                    stall = 0;
                    if (s_exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL s_unexpected_beat type=%0d", s_out_type);
                    end else begin
                        b = s_exp_q.pop_front();
                        check("s_beat_type", 64'(s_out_type), 64'(b.t));
                        check("s_beat_count", 64'(s_out_count), 64'(b.c));
                        check("s_beat_area", 64'(s_out_area), 64'(b.a));
                        check("s_beat_last", 64'(s_out_last), 64'(b.l));
                    end
                end else begin
                    stall = 1;
                    h_t = 64'(s_out_type); h_c = 64'(s_out_count); h_a = 64'(s_out_area);
                end
            end else stall = 0;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // ---------------- drivers ----------------
    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            if (++n > 500) begin fail_to("idle"); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_busy();
        int n = 0;
        forever begin
            @(negedge clk);
            if (busy) break;
            if (++n > 100) begin fail_to("busy"); break; end
        end
    endtask

    // Presents one record and waits until it is taken; checks the CALC cycle.
    task automatic send_rec(input int t, input int w, input int h);
        int n = 0;
        in_valid = 1'b1; in_type = 2'(t); in_w = DW'(w); in_h = DW'(h);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 100) begin fail_to("accept"); in_valid = 1'b0; return; end
            @(posedge clk); #1;
        end
        check("s_in_ready", 64'(s_in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_rec(t, w, h);
        @(negedge clk);
        check("err_illegal", 64'(err_illegal), 64'(t == 3));
        check("s_err_illegal", 64'(s_err_illegal), 64'(t == 3));
        check("busy_calc", 64'(busy), 64'(1));
        @(posedge clk); #1;
        check("err_pulse_end", 64'(err_illegal), 64'(0));
    endtask

    task automatic do_report();
        push_report();
        report_req = 1'b1;
        wait_busy();
        @(posedge clk); #1;
        report_req = 1'b0;
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, hs_before;
        model_zero(1'b1);

        // reset values
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_type", 64'(out_type), 64'(0));
        check("rst_out_count", 64'(out_count), 64'(0));
        check("rst_out_area", 64'(out_area), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_err", 64'(err_illegal), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic three-type flow: beats (0,1,12) (1,1,25) (2,1,7)
        send_rec(0, 3, 4);
        send_rec(1, 5, 7);
        send_rec(2, 3, 5);
        do_report();

        // illegal record leaves everything untouched
        send_rec(3, 9, 9);
        do_report();

        // in_valid held: accept every other cycle
        in_valid = 1'b1; in_type = 2'd0; in_w = DW'(2); in_h = DW'(2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_in_ready", 64'(in_ready), 64'(i % 2 == 0));
            if (in_ready) model_rec(0, 2, 2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        do_report();

        // out_ready low for 5 cycles on beat 1
        send_rec(0, 7, 3);
        send_rec(1, 6, 0);
        send_rec(2, 9, 9);
        hs_before = hs_cnt;
        push_report();
        report_req = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid && out_type == 2'd0) break;
            if (++n > 100) begin fail_to("beat0"); break; end
        end
        @(posedge clk); #1;
        report_req = 1'b0;
        dir_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_beat_type", 64'(out_type), 64'(1));
        check("stall_valid", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        dir_ready = 1'b1;
        wait_idle();
        check("stall_hs_total", 64'(hs_cnt - hs_before), 64'(3));

        // report_req and in_valid together: report wins, record follows
        send_rec(0, 6, 7);
        in_valid = 1'b1; in_type = 2'd1; in_w = DW'(4); in_h = DW'(0);
        report_req = 1'b1;
        push_report();
        @(negedge clk);
        check("prio_in_ready", 64'(in_ready), 64'(0));
        wait_busy();
        @(posedge clk); #1;
        report_req = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 100) begin fail_to("prio_accept"); break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_rec(1, 4, 0);
        wait_idle();
        do_report();

        // reset in the middle of a report
        send_rec(0, 2, 3);
        push_report();
        report_req = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            if (++n > 100) begin fail_to("rst_beat0"); break; end
        end
        @(posedge clk); #1;
        report_req = 1'b0;
        check("rst_mid_beat", 64'(out_type), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'(0));
        check("rst_async_s_valid", 64'(s_out_valid), 64'(0));
        check("rst_async_busy", 64'(busy), 64'(0));
        exp_q.delete();
        s_exp_q.delete();
        model_zero(1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_report();

        // saturation on the narrow instance; it also keeps totals between reports
        repeat (5) send_rec(0, 1, 1);
        send_rec(0, 15, 15);
        send_rec(0, 15, 15);
        do_report();
        do_report();

        // randomized traffic with random backpressure
        rnd_ready = 1'b1;
        repeat (60) begin
            int t, w, h;
            t = int'($urandom_range(0, 3));
            w = ($urandom_range(0, 3) == 0) ? 65535 : int'($urandom_range(0, 300));
            h = ($urandom_range(0, 3) == 0) ? 65535 : int'($urandom_range(0, 300));
            send_rec(t, w, h);
            if ($urandom_range(0, 7) == 0) do_report();
        end
        do_report();
        rnd_ready = 1'b0;

        check("exp_q_empty", 64'(exp_q.size()), 64'(0));
        check("s_exp_q_empty", 64'(s_exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
